// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way cache: state encoding, default geometry, way ids.
package cache_pkg;

    localparam int INDEX_W = 5;
    localparam int TAG_W   = 8;
    localparam int DATA_W  = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t REQ   = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t WRITE = 2'd3;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    function automatic logic [1:0] way_onehot(input logic way);
        return (way == WAY1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_2way_if.sv
// Lookup, memory-fetch and way-write signals of the fill controller.
interface cache_fill_ctrl_2way_if #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int TAG_W   = cache_pkg::TAG_W,
    parameter int DATA_W  = cache_pkg::DATA_W
);
    logic                     req_valid;
    logic                     req_ready;
    logic [INDEX_W-1:0]       req_index;
    logic [TAG_W-1:0]         req_tag;
    logic                     hit0;
    logic                     hit1;
    logic                     vld0;
    logic                     vld1;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [TAG_W+INDEX_W-1:0] mem_req_addr;
    logic                     mem_resp_valid;
    logic [DATA_W-1:0]        mem_resp_data;
    logic [1:0]               way_we;
    logic [INDEX_W-1:0]       way_index;
    logic [TAG_W-1:0]         way_tag;
    logic [DATA_W-1:0]        way_data;
    logic                     fill_done;

    // master = the fill controller
    modport master (
        input  req_valid, req_index, req_tag, hit0, hit1, vld0, vld1,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, mem_req_valid, mem_req_addr,
        output way_we, way_index, way_tag, way_data, fill_done
    );

    modport slave (
        output req_valid, req_index, req_tag, hit0, hit1, vld0, vld1,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  way_we, way_index, way_tag, way_data, fill_done
    );
endinterface

// File: rtl/lru_array_2way.sv
// Per-set LRU bit (way to evict next), async clear, one comb read and one write port.
module lru_array_2way #(
    parameter int INDEX_W = cache_pkg::INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_bit,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_bit
);
    logic [(1<<INDEX_W)-1:0] lru_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else if (we) begin
            lru_q[wr_index] <= wr_bit;
        end
    end

    assign rd_bit = lru_q[rd_index];

endmodule

// File: rtl/cache_fill_ctrl_2way.sv
// Miss handling and victim allocation for the 2-way cache; steers each fill into one way.
//
// state | meaning
// IDLE  | accepting lookups; hits update LRU, misses latch set/tag/victim
// REQ   | line fetch presented to memory, address held
// WAIT  | fetch accepted, waiting for returned line
// WRITE | one-cycle write of the line into the victim way
module cache_fill_ctrl_2way #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int TAG_W   = cache_pkg::TAG_W,
    parameter int DATA_W  = cache_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_fill_ctrl_2way_if.master bus
);
    import cache_pkg::*;

    state_t             state;
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic               victim_q;
    logic [DATA_W-1:0]  data_q;

    logic               lru_rd;
    logic               lru_we;
    logic [INDEX_W-1:0] lru_wr_index;
    logic               lru_wr_bit;
    logic               victim_sel;
    logic               hit;
    logic               accept;

    assign hit    = bus.hit0 | bus.hit1;
    assign accept = (state == IDLE) && bus.req_valid;

    // invalid ways are filled before LRU is consulted
    always_comb begin
        if (!bus.vld0) begin
            victim_sel = WAY0;
        end else if (!bus.vld1) begin
            victim_sel = WAY1;
        end else begin
            victim_sel = lru_rd;
        end
    end

    // hit0 wins when both hit, so the next victim is way1
    always_comb begin
        lru_we       = 1'b0;
        lru_wr_index = idx_q;
        lru_wr_bit   = ~victim_q;
        if (state == WRITE) begin
            lru_we = 1'b1;
        end else if (accept && hit) begin
            lru_we       = 1'b1;
            lru_wr_index = bus.req_index;
            lru_wr_bit   = bus.hit0 ? WAY1 : WAY0;
        end
    end

    lru_array_2way #(.INDEX_W(INDEX_W)) u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (bus.req_index),
        .rd_bit   (lru_rd),
        .we       (lru_we),
        .wr_index (lru_wr_index),
        .wr_bit   (lru_wr_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            tag_q    <= '0;
            victim_q <= WAY0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !hit) begin
                        idx_q    <= bus.req_index;
                        tag_q    <= bus.req_tag;
                        victim_q <= victim_sel;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        data_q <= bus.mem_resp_data;
                        state  <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = {tag_q, idx_q};
    assign bus.way_we        = (state == WRITE) ? way_onehot(victim_q) : 2'b00;
    assign bus.way_index     = idx_q;
    assign bus.way_tag       = tag_q;
    assign bus.way_data      = data_q;
    assign bus.fill_done     = (state == WRITE);

endmodule

// File: tb/tb_cache_fill_ctrl_2way.sv
// Randomized bench for cache_fill_ctrl_2way against a tag/valid/LRU cache model.
module tb_cache_fill_ctrl_2way;
    localparam int IW = 5;
    localparam int TW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_fill_ctrl_2way_if #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) bus ();

    cache_fill_ctrl_2way #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // model of the cache contents the tag-compare logic would see
    bit            m_vld [32][2];
    logic [TW-1:0] m_tag [32][2];
    bit            m_lru [32];

    int vectors    = 0;
    int miscompares = 0;

    initial begin
        #200us;
        $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1);
    end

    // One lookup; miss path walks REQ (rdly extra stall cycles) and WAIT (sdly cycles).
    task automatic lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input bit frc,
                          input logic [3:0] fv, input int rdly, input int sdly,
                          input logic [DW-1:0] data);
        logic h0, h1, v0, v1, way;
        logic [1:0] exp_we;
        logic [TW+IW-1:0] exp_addr;
        if (frc) begin
            {h0, h1, v0, v1} = fv;
        end else begin
            v0 = m_vld[idx][0];
            v1 = m_vld[idx][1];
            h0 = v0 && (m_tag[idx][0] == tag);
            h1 = v1 && (m_tag[idx][1] == tag);
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
        end
        bus.req_valid = 1'b1; bus.req_index = idx; bus.req_tag = tag;
        bus.hit0 = h0; bus.hit1 = h1; bus.vld0 = v0; bus.vld1 = v1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.hit0 = 1'b0; bus.hit1 = 1'b0;
        bus.req_index = IW'($urandom); bus.vld0 = 1'b0; bus.vld1 = 1'b0;
        if (h0 || h1) begin
            vectors++;
            if ({bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done} !== 5'b10000) begin
                miscompares++;
                $display("FAIL hit_no_traffic idx=%0d: got rdy/mreq/we/done=%b want 10000", idx,
                         {bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done});
            end
            m_lru[idx] = h0 ? 1'b1 : 1'b0;
        end else begin
            way      = !v0 ? 1'b0 : (!v1 ? 1'b1 : m_lru[idx]);
            exp_we   = way ? 2'b10 : 2'b01;
            exp_addr = {tag, idx};
            for (int i = 0; i <= rdly; i++) begin
                vectors++;
                if ({bus.req_ready, bus.mem_req_valid, bus.way_we} !== 4'b0100 ||
                    bus.mem_req_addr !== exp_addr) begin
                    miscompares++;
                    $display("FAIL req_phase cyc=%0d: got rdy/mreq/we=%b addr=%h want 0100 addr=%h", i,
                             {bus.req_ready, bus.mem_req_valid, bus.way_we}, bus.mem_req_addr, exp_addr);
                end
                bus.mem_req_ready  = (i == rdly);
                bus.mem_resp_valid = 1'($urandom_range(1));
                bus.mem_resp_data  = $urandom;
                @(posedge clk); #1;
            end
            bus.mem_req_ready = 1'b0;
            for (int j = 0; j <= sdly; j++) begin
                vectors++;
                if ({bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done} !== 5'b00000) begin
                    miscompares++;
                    $display("FAIL wait_phase cyc=%0d: got rdy/mreq/we/done=%b want 00000", j,
                             {bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done});
                end
                bus.mem_resp_valid = (j == sdly);
                bus.mem_resp_data  = (j == sdly) ? data : $urandom;
                @(posedge clk); #1;
            end
            bus.mem_resp_valid = 1'b0;
            vectors++;
            if (bus.way_we !== exp_we || bus.fill_done !== 1'b1 || bus.way_index !== idx ||
                bus.way_tag !== tag || bus.way_data !== data) begin
                miscompares++;
                $display("FAIL write_cycle: got we=%b done=%b idx=%0d tag=%h data=%h want we=%b done=1 idx=%0d tag=%h data=%h",
                         bus.way_we, bus.fill_done, bus.way_index, bus.way_tag, bus.way_data,
                         exp_we, idx, tag, data);
            end
            @(posedge clk); #1;
            vectors++;
            if ({bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done} !== 5'b10000) begin
                miscompares++;
                $display("FAIL after_write: got rdy/mreq/we/done=%b want 10000",
                         {bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done});
            end
            m_vld[idx][way] = 1'b1;
            m_tag[idx][way] = tag;
            m_lru[idx]      = ~way;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 0; bus.req_index = '0; bus.req_tag = '0;
        bus.hit0 = 0; bus.hit1 = 0; bus.vld0 = 0; bus.vld1 = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
        #12;
        vectors++;
        if ({bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.way_we, bus.way_index,
             bus.way_tag, bus.way_data, bus.fill_done} !== {1'b1, 1'b0, 13'h0, 2'b00, 5'h0, 8'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b mreq=%b addr=%h we=%b idx=%h tag=%h data=%h done=%b",
                     bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.way_we, bus.way_index,
                     bus.way_tag, bus.way_data, bus.fill_done);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_miss_fill();
        lookup(5'd5, 8'h3A, 1'b0, 4'b0000, 0, 0, 32'hDEADBEEF);
        lookup(5'd5, 8'h11, 1'b0, 4'b0000, 0, 1, $urandom);
    endtask

    task automatic test_lru_hits();
        lookup(5'd9, 8'h40, 1'b0, 4'b0000, 0, 0, $urandom);
        lookup(5'd9, 8'h41, 1'b0, 4'b0000, 1, 0, $urandom);
        lookup(5'd9, 8'h41, 1'b0, 4'b0000, 0, 0, '0);
        lookup(5'd9, 8'h40, 1'b0, 4'b0000, 0, 0, '0);
        lookup(5'd9, 8'h42, 1'b0, 4'b0000, 0, 0, $urandom);
    endtask

    task automatic test_stall();
        lookup(5'd17, 8'h5C, 1'b0, 4'b0000, 4, 3, $urandom);
    endtask

    task automatic test_index_wrap();
        lookup(5'd31, 8'hFF, 1'b0, 4'b0000, 0, 0, $urandom);
        lookup(5'd0, 8'hFF, 1'b0, 4'b0000, 0, 0, $urandom);
    endtask

    task automatic test_illegal_hit();
        lookup(5'd2, 8'h00, 1'b1, 4'b1111, 0, 0, '0);
        lookup(5'd2, 8'h77, 1'b1, 4'b0011, 0, 0, $urandom);
    endtask

    task automatic test_reset_mid();
        lookup(5'd9, m_tag[9][0], 1'b0, 4'b0000, 0, 0, '0);
        bus.req_valid = 1'b1; bus.req_index = 5'd12; bus.req_tag = 8'hC3;
        bus.hit0 = 0; bus.hit1 = 0; bus.vld0 = 0; bus.vld1 = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.way_we, bus.way_index,
             bus.way_tag, bus.way_data, bus.fill_done} !== {1'b1, 1'b0, 13'h0, 2'b00, 5'h0, 8'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset_values: got rdy=%b mreq=%b addr=%h we=%b idx=%h tag=%h done=%b",
                     bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.way_we, bus.way_index,
                     bus.way_tag, bus.fill_done);
        end
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp_data = $urandom;
            @(posedge clk); #1;
            vectors++;
            if ({bus.way_we, bus.fill_done} !== 3'b000) begin
                miscompares++;
                $display("FAIL in_reset_no_write: got we/done=%b want 000", {bus.way_we, bus.fill_done});
            end
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done} !== 5'b10000) begin
                miscompares++;
                $display("FAIL resp_ignored_idle: got rdy/mreq/we/done=%b want 10000",
                         {bus.req_ready, bus.mem_req_valid, bus.way_we, bus.fill_done});
            end
        end
        bus.mem_resp_valid = 1'b0;
        foreach (m_lru[s]) m_lru[s] = 1'b0;
        lookup(5'd9, 8'h99, 1'b0, 4'b0000, 0, 0, $urandom);
    endtask

    task automatic test_random();
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        int w;
        for (int n = 0; n < 60; n++) begin
            idx = IW'($urandom_range(31));
            w   = $urandom_range(1);
            if ($urandom_range(1) == 1 && m_vld[idx][w]) begin
                tag = m_tag[idx][w];
            end else begin
                tag = TW'($urandom);
                while ((m_vld[idx][0] && m_tag[idx][0] == tag) || (m_vld[idx][1] && m_tag[idx][1] == tag))
                    tag = tag + 8'd1;
            end
            lookup(idx, tag, 1'b0, 4'b0000, $urandom_range(2), $urandom_range(2), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_lru_hits();
        test_stall();
        test_index_wrap();
        test_illegal_hit();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
